dtlb_ctrl: RTL
==============

DTLB_CTRL -- requirements
Module: dtlb_ctrl

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, data/address width.
REQ-002 SHALL have parameter ENTRIES, default 4, number of line-entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  translation request.
REQ-006 SHALL have port req_vaddr  input  64  virtual address (Sv48-style, bits 47:0 used).
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid & req_ready.
REQ-008 SHALL have port resp_valid  output  1  one-cycle response pulse, no backpressure.
REQ-009 SHALL have port resp_paddr  output  64  physical address.
REQ-010 SHALL have port resp_fault  output  1  selected PTE invalid (PTE bit 0 == 0).
REQ-011 SHALL have port flush  input  1  invalidate all entries.
REQ-012 SHALL have port walk_enable  output  1  start page-table walk, one-cycle pulse.
REQ-013 SHALL have port walk_vaddr  output  64  address to walk, held stable from WALK_START until walk completes.
REQ-014 SHALL have port walk_ready  input  1  walk complete, walk_ptes valid.
REQ-015 SHALL have port walk_ptes  input  512  eight leaf PTEs of one cache line; PTE k at bits 64k+63:64k.

Function
REQ-016 SHALL implement states IDLE, LOOKUP, WALK_START, WALK_WAIT, FILL, RESP.
REQ-017 SHALL drive req_ready = 1 only in IDLE with flush == 0; on acceptance latch req_vaddr and go to LOOKUP.
REQ-018 SHALL store per entry: valid bit, tag = vaddr[47:15] (33 bits), eight 64-bit PTEs.
REQ-019 SHALL in LOOKUP compare the latched tag against all valid entries; on hit go to RESP, on miss go to WALK_START.
REQ-020 SHALL select the PTE by latched vaddr[14:12].
REQ-021 SHALL compute resp_paddr = ((PTE[63:10] << 12) truncated to 64 bits) | vaddr[11:0] when PTE[0] == 1, otherwise resp_paddr = 0 and resp_fault = 1.
REQ-022 SHALL give a hit latency of 2 cycles: acceptance edge -> LOOKUP -> resp_valid high in RESP; RESP returns to IDLE.
REQ-023 SHALL assert walk_enable for exactly one cycle in WALK_START, then go to WALK_WAIT.
REQ-024 SHALL drive walk_vaddr = latched vaddr in WALK_START and WALK_WAIT.
REQ-025 SHALL in WALK_WAIT ignore walk_ready in the WALK_START cycle and sample it from the next cycle; on walk_ready == 1 capture walk_ptes and go to FILL.
REQ-026 SHALL in FILL install the captured line at the victim index and go to RESP, answering from the captured PTEs.
REQ-027 SHALL select as victim the lowest-index invalid entry; if no entry is invalid, it SHALL use the round-robin pointer.
REQ-028 SHALL advance the round-robin pointer modulo ENTRIES only when it is used for replacement.
REQ-029 SHALL install entries regardless of PTE valid bits; faults are evaluated per PTE at response time.
REQ-030 SHALL on flush in IDLE clear all valid bits at the next edge; flush has priority over a simultaneous req_valid, and the request is not accepted that cycle.
REQ-031 SHALL on flush in any non-IDLE state set flush_pending. When flush_pending is set, FILL SHALL skip installation, the response SHALL still be produced from the captured PTEs, and all valid bits SHALL be cleared when returning to IDLE.
REQ-032 SHALL never hold two valid entries with equal tags.

Reset
REQ-033 SHALL on reset go to IDLE, clear all valid bits, clear flush_pending, and set the round-robin pointer to 0.
REQ-034 SHALL hold, during and after reset, req_ready=0 while reset is asserted, resp_valid=0, resp_fault=0, resp_paddr=0, walk_enable=0, walk_vaddr=0.
REQ-035 SHALL on reset mid-walk abandon the walk and produce no response.

Verification
REQ-036 SHALL verify cold miss: vaddr 0x40003ABC with walk_ptes PTE3 = 0x20000401 -> one walk_enable pulse, walk_vaddr 0x40003ABC, resp_paddr 0x80001ABC, resp_fault 0.
REQ-037 SHALL verify hit: vaddr 0x40003FF0 following REQ-036 -> resp_valid 2 cycles after acceptance, paddr 0x80001FF0, no walk_enable; vaddr 0x40005000 with PTE5 = 0x20000801 -> hit, paddr 0x80002000.
REQ-038 SHALL verify fault: PTE at the selected index = 0x20000400 -> resp_fault 1, resp_paddr 0.
REQ-039 SHALL verify replacement: five distinct tags (vaddr 0x0000, 0x8000, 0x10000, 0x18000, 0x20000) -> the fifth fills entry 0; re-request of 0x0000 misses and walks.
REQ-040 SHALL verify flush: flush asserted in WALK_WAIT -> response delivered; next request to the same vaddr misses. Flush with req_valid in IDLE -> req_ready 0 that cycle.
REQ-041 SHALL verify reset in WALK_WAIT -> no resp_valid; the next request misses.

Source files
------------

// File: rtl/dtlb_ctrl.sv
// dtlb_ctrl: fully associative data TLB; each entry caches one 8-PTE leaf line, misses go to a page-table walker.
// Latency: hit responds 2 cycles after acceptance; miss adds walk start, walker wait and one fill cycle.
// Backpressure: single request in flight, req_ready only in IDLE without flush; responses are never stalled.
module dtlb_ctrl #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ENTRIES        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [BUS_DATA_WIDTH-1:0] req_vaddr,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic [BUS_DATA_WIDTH-1:0] resp_paddr,
  output logic                      resp_fault,
  input  logic                      flush,
  output logic                      walk_enable,
  output logic [BUS_DATA_WIDTH-1:0] walk_vaddr,
  input  logic                      walk_ready,
  input  logic [511:0]              walk_ptes
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WALK_START,
    WALK_WAIT,
    FILL,
    RESP
  } state_t;

  state_t                    state;
  state_t                    state_nxt;

  logic [BUS_DATA_WIDTH-1:0] vaddr_q;
  logic [511:0]              line_q;
  logic [ENTRIES-1:0]        valid_q;
  logic [32:0]               tag_mem  [ENTRIES];
  logic [511:0]              line_mem [ENTRIES];
  logic                      flush_pending;
  logic [IW-1:0]             rr_ptr;

  logic                      hit;
  logic [IW-1:0]             hit_idx;
  logic                      has_invalid;
  logic [IW-1:0]             victim;
  logic [32:0]               req_tag;
  logic [2:0]                pte_sel;
  logic [63:0]               sel_pte;
  logic [63:0]               paddr_full;
  logic                      accept;
  logic                      install;

  assign req_tag    = vaddr_q[47:15];
  assign pte_sel    = vaddr_q[14:12];
  // Response always comes from line_q: loaded from the hit entry in LOOKUP or from the walker in WALK_WAIT.
  assign sel_pte    = line_q[{pte_sel, 6'd0} +: 64];
  assign paddr_full = ((sel_pte >> 10) << 12) | {52'd0, vaddr_q[11:0]};
  assign accept     = req_valid && req_ready;
  // A flush seen during this translation drops the install; the line would be invalidated at IDLE anyway.
  assign install    = (state == FILL) && !flush_pending;

  // Tag match against every valid entry; tags are unique so at most one entry hits.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_mem[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Victim: lowest-index invalid entry, else the round-robin pointer.
  always_comb begin
    has_invalid = 1'b0;
    victim      = rr_ptr;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        has_invalid = 1'b1;
        victim      = IW'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; walk_ready is only looked at once WALK_WAIT is reached.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (accept) state_nxt = LOOKUP;
      LOOKUP:     state_nxt = hit ? RESP : WALK_START;
      WALK_START: state_nxt = WALK_WAIT;
      WALK_WAIT:  if (walk_ready) state_nxt = FILL;
      FILL:       state_nxt = RESP;
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; everything held low while reset is asserted.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_paddr  = '0;
    resp_fault  = 1'b0;
    walk_enable = 1'b0;
    walk_vaddr  = '0;
    if (!reset) begin
      case (state)
        IDLE:       req_ready = !flush;
        WALK_START: begin
          walk_enable = 1'b1;
          walk_vaddr  = vaddr_q;
        end
        WALK_WAIT:  walk_vaddr = vaddr_q;
        RESP: begin
          resp_valid = 1'b1;
          if (sel_pte[0]) begin
            resp_paddr = BUS_DATA_WIDTH'(paddr_full);
          end else begin
            resp_fault = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state: request latch, response line, valid bits, flush bookkeeping, replacement pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      vaddr_q       <= '0;
      line_q        <= '0;
      valid_q       <= '0;
      flush_pending <= 1'b0;
      rr_ptr        <= '0;
    end else begin
      if (accept) begin
        vaddr_q <= req_vaddr;
      end
      if ((state == LOOKUP) && hit) begin
        line_q <= line_mem[hit_idx];
      end
      if ((state == WALK_WAIT) && walk_ready) begin
        line_q <= walk_ptes;
      end
      if (install) begin
        valid_q[victim] <= 1'b1;
        if (!has_invalid) begin
          rr_ptr <= rr_ptr + 1'b1;
        end
      end
      if (state == RESP) begin
        flush_pending <= 1'b0;
      end else if ((state != IDLE) && flush) begin
        flush_pending <= 1'b1;
      end
      if (((state == IDLE) && flush) || ((state == RESP) && (flush || flush_pending))) begin
        valid_q <= '0;
      end
    end
  end

  // Tag and PTE storage; contents only matter under the matching valid bit.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_mem[victim]  <= req_tag;
      line_mem[victim] <= line_q;
    end
  end

endmodule
